multdiv_seq: RTL and testbench
==============================

Name: multdiv_seq

Overview:
- Iterative signed 32-bit multiply/divide unit in the ALU.
- Consumes the same operand pair as the barrel shifters (sll32/sra32) and the adder.
- Uses internal 1-bit shift/add and shift/subtract steps; produces a registered result with a ready pulse.
- The processor stalls on a MULT/DIV instruction until data_resultRDY, then writes data_result back.

Parameters:
WIDTH, 32, operand/result width; must be even; only 32 is verified.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears all state
data_operandA  input  WIDTH  multiplicand / dividend (two's complement)
data_operandB  input  WIDTH  multiplier / divisor (two's complement)
ctrl_MULT  input  1  start-multiply pulse, sampled on clock edge
ctrl_DIV  input  1  start-divide pulse, sampled on clock edge
data_result  output  WIDTH  low WIDTH bits of product, or quotient
data_exception  output  1  overflow / divide-by-zero flag, valid with result
data_resultRDY  output  1  one-cycle pulse: result and exception valid
busy  output  1  high while an operation is in progress

Behaviour:
- Reset is asynchronous and active-high, with one clock.
- Reset values: state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0.
- Reset mid-operation aborts the operation. No data_resultRDY is produced for it.
- States and transitions:
  - IDLE: idle state.
  - MUL: when ctrl_MULT is sampled, latch A and B and go to MUL.
  - DIV: when ctrl_DIV is sampled, latch A and B and go to DIV.
  - DONE: entered when the counter reaches WIDTH.
  - DONE to IDLE: unconditional on the next edge.
- busy=1 in MUL, DIV and DONE.
- Start priority:
  - ctrl_MULT and ctrl_DIV both high: MULT wins and DIV is ignored.
  - A start sampled in any non-IDLE state aborts the current operation and restarts with the new operands. The aborted operation gives no ready pulse.
- MUL: radix-2 shift-add on 2*WIDTH-bit accumulator {P, multiplier}, one iteration per edge, WIDTH iterations. Signed operands are handled via magnitude and sign fix-up, or via Booth radix-2; either is permitted as long as the result is identical.
- DIV: restoring division on the magnitudes, one quotient bit per edge, WIDTH iterations.
  - Quotient sign = sign(A) XOR sign(B).
  - Truncates toward zero; remainder is discarded.
- Latency: start sampled at edge E0; iterations at E1..E_WIDTH; data_resultRDY=1 for exactly the cycle after edge E_(WIDTH+1). For WIDTH=32 that is 33 edges.
- data_result and data_exception update at the same edge data_resultRDY rises, and hold until the next completion or reset.
- Exceptions:
  - MUL: exception=1 if the full 2*WIDTH-bit signed product has its upper WIDTH+1 bits not all equal. data_result still carries the low WIDTH bits.
  - DIV by 0: data_result=0, exception=1.
  - DIV of most-negative / -1: data_result=0x80000000, exception=1.
  - Otherwise exception=0.
- Operand inputs are ignored after the start edge. The latched copies are used throughout.

Optional Feature:
MULTDIV_BOOTH4_EN:
- Defined: MUL uses radix-4 modified Booth recoding, 2 bits per iteration, WIDTH/2 iterations. Multiply data_resultRDY follows edge E_(WIDTH/2+1), i.e. 17 edges. DIV is unchanged.
- Undefined: radix-2 multiply, latency WIDTH+1.
- Results and exceptions are identical in both builds.

Test Plan:
- reset pulse mid-multiply (start 3*4, assert reset at E5) -> all outputs 0 immediately; no data_resultRDY for the next 40 cycles.
- ctrl_MULT, A=7, B=-6 -> data_resultRDY one cycle after E33 (E17 with BOOTH4), data_result=0xFFFFFFD6, exception=0, busy low after pulse.
- ctrl_MULT, A=0x00010000, B=0x00010000 -> data_result=0x00000000, exception=1.
- DIV cases:
  - ctrl_DIV, A=-7, B=2 -> data_result=0xFFFFFFFD, exception=0.
  - ctrl_DIV, A=5, B=0 -> data_result=0, exception=1.
  - ctrl_DIV, A=0x80000000, B=-1 -> data_result=0x80000000, exception=1.
- ctrl_MULT and ctrl_DIV both high, A=100, B=5 -> multiply performed, data_result=500.
- ctrl_MULT (A=9, B=9) at E0, then ctrl_DIV (A=100, B=7) at E10 -> single data_resultRDY at E43, data_result=14, exception=0.

Source files
------------

// File: rtl/multdiv_seq.sv
// multdiv_seq: iterative signed multiply/divide unit.
// Multiply is shift-add on magnitudes with a sign fix-up at the end.
// Divide is restoring division on magnitudes, one quotient bit per edge.
// Optional build macro MULTDIV_BOOTH4_EN: the multiply uses radix-4 modified
// Booth recoding on the signed operands instead (WIDTH/2 iterations).
// Results and exceptions are the same in both builds.
module multdiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

`ifdef MULTDIV_BOOTH4_EN
  // Booth partial products reach +/-2M, so the upper half needs two guard bits.
  localparam int MUL_ITERS = WIDTH / 2;
  localparam int HW        = WIDTH + 2;
`else
  // The shift-add carry out of the upper half needs one guard bit.
  localparam int MUL_ITERS = WIDTH;
  localparam int HW        = WIDTH + 1;
`endif

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_ITERS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] count;

  // hi/lo together form the double-width accumulator: {P, multiplier} when
  // multiplying, {remainder, dividend/quotient} when dividing.
  logic [HW-1:0]      hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   mcand;
  logic               neg;
  logic               is_div;

  logic [HW-1:0]      mul_hi_nx;
  logic [WIDTH-1:0]   mul_lo_nx;
  logic [HW-1:0]      div_hi_nx;
  logic [WIDTH-1:0]   div_lo_nx;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH+1:0]   rem_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     prod_top;
  logic [WIDTH-1:0]   fin_result;
  logic               fin_exc;

`ifdef MULTDIV_BOOTH4_EN
  logic          qm1;
  logic          qm1_nx;
  logic [HW-1:0] m_ext;
  logic [HW-1:0] addend;
  logic [HW-1:0] booth_sum;
`else
  logic [WIDTH:0] add_sum;
`endif

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  // State register; an async reset drops any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state: a start pulse always wins and restarts, MULT over DIV.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = IDLE;
      MUL:     if (count == MUL_LAST) state_nx = DONE;
      DIV:     if (count == DIV_LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (ctrl_MULT)     state_nx = MUL;
    else if (ctrl_DIV) state_nx = DIV;
  end

  // One multiply step, one restoring-divide step, and the final fix-up.
  always_comb begin
`ifdef MULTDIV_BOOTH4_EN
    m_ext = {{2{mcand[WIDTH-1]}}, mcand};
    case ({lo[1:0], qm1})
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m_ext << 1;
      3'b100:         addend = -(m_ext << 1);
      3'b101, 3'b110: addend = -m_ext;
      default:        addend = '0;
    endcase
    booth_sum = hi + addend;
    mul_hi_nx = {{2{booth_sum[HW-1]}}, booth_sum[HW-1:2]};
    mul_lo_nx = {booth_sum[1:0], lo[WIDTH-1:2]};
    qm1_nx    = lo[1];
    prod      = {hi[WIDTH-1:0], lo};
`else
    add_sum   = hi + (lo[0] ? {1'b0, mcand} : '0);
    mul_hi_nx = {1'b0, add_sum[WIDTH:1]};
    mul_lo_nx = {add_sum[0], lo[WIDTH-1:1]};
    prod      = neg ? -{hi[WIDTH-1:0], lo} : {hi[WIDTH-1:0], lo};
`endif

    rem_shift = {hi[WIDTH-1:0], lo[WIDTH-1]};
    rem_diff  = {1'b0, rem_shift} - {2'b00, mcand};
    if (rem_diff[WIDTH+1]) div_hi_nx = HW'(rem_shift);
    else                   div_hi_nx = HW'(rem_diff[WIDTH:0]);
    div_lo_nx = {lo[WIDTH-2:0], ~rem_diff[WIDTH+1]};

    // Product overflows when the top WIDTH+1 bits are not a pure sign extension.
    prod_top = prod[2*WIDTH-1:WIDTH-1];
    if (is_div) begin
      if (mcand == '0) begin
        fin_result = '0;
        fin_exc    = 1'b1;
      end else begin
        // A positive quotient of magnitude 2^(WIDTH-1) only comes from MIN / -1.
        fin_result = neg ? -lo : lo;
        fin_exc    = ~neg & lo[WIDTH-1];
      end
    end else begin
      fin_result = prod[WIDTH-1:0];
      fin_exc    = (prod_top != '0) && (prod_top != '1);
    end
  end

  // Operand latch on start, then one iteration per edge while busy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
      mcand  <= '0;
      neg    <= 1'b0;
      is_div <= 1'b0;
`ifdef MULTDIV_BOOTH4_EN
      qm1    <= 1'b0;
`endif
    end else if (ctrl_MULT) begin
      count  <= '0;
      hi     <= '0;
      is_div <= 1'b0;
`ifdef MULTDIV_BOOTH4_EN
      lo     <= data_operandB;
      mcand  <= data_operandA;
      neg    <= 1'b0;
      qm1    <= 1'b0;
`else
      lo     <= magnitude(data_operandB);
      mcand  <= magnitude(data_operandA);
      neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
`endif
    end else if (ctrl_DIV) begin
      count  <= '0;
      hi     <= '0;
      is_div <= 1'b1;
      lo     <= magnitude(data_operandA);
      mcand  <= magnitude(data_operandB);
      neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
    end else if (state == MUL) begin
      count  <= count + CNT_W'(1);
      hi     <= mul_hi_nx;
      lo     <= mul_lo_nx;
`ifdef MULTDIV_BOOTH4_EN
      qm1    <= qm1_nx;
`endif
    end else if (state == DIV) begin
      count  <= count + CNT_W'(1);
      hi     <= div_hi_nx;
      lo     <= div_lo_nx;
    end
  end

  // Publish the result with a one-cycle ready pulse unless a restart arrives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (state == DONE && !ctrl_MULT && !ctrl_DIV) begin
        data_result    <= fin_result;
        data_exception <= fin_exc;
        data_resultRDY <= 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_multdiv_seq.sv
// tb_multdiv_seq: randomized and directed checks of multdiv_seq against a
// plain-arithmetic reference model. Honours MULTDIV_BOOTH4_EN for latency.
module tb_multdiv_seq;

`ifdef MULTDIV_BOOTH4_EN
  localparam int MUL_LAT = 17;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checksTotal  = 0;
  int checksPassed = 0;

  multdiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case something wedges the stimulus flow.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
  endtask

  // Reference: exact 64-bit arithmetic, then the overflow rules.
  function automatic void refModel(input bit isMul, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] res, output bit exc);
    longint pa, pb, p;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    if (isMul) begin
      p   = pa * pb;
      res = p[31:0];
      exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (b == 32'd0) begin
      res = 32'd0;
      exc = 1'b1;
    end else begin
      p   = pa / pb;
      res = p[31:0];
      exc = (p > 64'sd2147483647);
    end
  endfunction

  function automatic logic [31:0] pickOperand();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0:       v = 32'h0000_0000;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = 32'h7FFF_FFFF;
      4, 5:    v = 32'($urandom_range(0, 4000)) - 32'd2000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Present a start pulse for one edge (E0), then scramble the operands.
  task automatic applyStimulus(input bit isMul, input bit isDiv, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT     = isMul;
    ctrl_DIV      = isDiv;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    checkOutput("busy_after_start", busy, 1'b1);
  endtask

  task automatic waitResult(input string tag, input int expLat, input logic [31:0] expRes, input bit expExc);
    int  edges;
    bit  seen;
    logic [31:0] held;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 80) begin
      @(posedge clock);
      #1;
      edges++;
      if (data_resultRDY === 1'b1) seen = 1'b1;
    end
    checkOutput({tag, ".rdy_seen"}, seen, 1'b1);
    if (seen) begin
      checkOutput({tag, ".latency"}, edges, expLat);
      checkOutput({tag, ".result"}, data_result, expRes);
      checkOutput({tag, ".exception"}, data_exception, expExc);
      checkOutput({tag, ".busy_at_rdy"}, busy, 1'b0);
      held = data_result;
      @(posedge clock);
      #1;
      checkOutput({tag, ".rdy_one_cycle"}, data_resultRDY, 1'b0);
      checkOutput({tag, ".result_hold"}, data_result, held);
    end
  endtask

  task automatic runOp(input string tag, input bit isMul, input bit isDiv, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] expRes;
    bit          expExc;
    refModel(isMul, a, b, expRes, expExc);
    applyStimulus(isMul, isDiv, a, b);
    waitResult(tag, isMul ? MUL_LAT : DIV_LAT, expRes, expExc);
  endtask

  initial begin
    int rdyCount;
    logic [31:0] expRes;
    bit          expExc;

    reset         = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #2 reset = 1'b1;
    #1;
    checkOutput("reset.result", data_result, 32'd0);
    checkOutput("reset.exception", data_exception, 1'b0);
    checkOutput("reset.rdy", data_resultRDY, 1'b0);
    checkOutput("reset.busy", busy, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    runOp("mul_7_m6", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA);
    runOp("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    runOp("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    runOp("div_by_0", 1'b0, 1'b1, 32'd5, 32'd0);
    runOp("div_min_m1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp("both_high", 1'b1, 1'b1, 32'd100, 32'd5);

    // Reset in the middle of a multiply: outputs clear at once, no ready later.
    applyStimulus(1'b1, 1'b0, 32'd3, 32'd4);
    repeat (4) @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    checkOutput("midreset.result", data_result, 32'd0);
    checkOutput("midreset.exception", data_exception, 1'b0);
    checkOutput("midreset.rdy", data_resultRDY, 1'b0);
    checkOutput("midreset.busy", busy, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    rdyCount = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (data_resultRDY === 1'b1) rdyCount++;
    end
    checkOutput("midreset.no_rdy", rdyCount, 0);

    // Restart: a divide at E10 aborts the multiply started at E0.
    refModel(1'b0, 32'd100, 32'd7, expRes, expExc);
    applyStimulus(1'b1, 1'b0, 32'd9, 32'd9);
    repeat (9) @(posedge clock);
    applyStimulus(1'b0, 1'b1, 32'd100, 32'd7);
    waitResult("restart", DIV_LAT, expRes, expExc);

    for (int i = 0; i < 40; i++) begin
      bit isMul;
      isMul = 1'($urandom_range(0, 1));
      runOp(isMul ? "rand_mul" : "rand_div", isMul, ~isMul, pickOperand(), pickOperand());
    end

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
